// File: rtl/ocx_tlx_dcp_xmt_credit_ctl.sv
// ---------------------------------------------------------------------------
// ocx_tlx_dcp_xmt_credit_ctl
//
// Transmit-side data credit pool controller. The remote receive FIFO returns
// one data-buffer credit per credit_return_v pulse. A burst of 512-bit beats
// from the local source buffer is released to the framer only after credits
// for the whole burst are held. Each transmitted beat consumes one credit.
//
// Optional build macro:
//   OCX_TLX_DCP_XMT_OVERFLOW_CHK_EN - builds sticky detection of credit
//   returns dropped at the saturated count (credit_overflow). Without it,
//   credit_overflow is tied low. Saturation itself is identical in both
//   builds.
//
// Ports:
//   tlx_clk          clock
//   reset_n          asynchronous active-low reset
//   credit_return_v  one credit returned per cycle high
//   xmt_req_v        burst request valid
//   xmt_req_cnt      encoded burst length
//   xmt_req_ready    request accepted when xmt_req_v & xmt_req_ready
//   src_data_v       source buffer has a beat available
//   src_data_bus     source beat
//   src_data_rd      pop one beat from the source this cycle
//   link_stall       framer cannot take a beat this cycle
//   fp_xmt_data_v    beat valid to framer (registered src_data_rd)
//   fp_xmt_data_bus  beat to framer (registered src_data_bus)
//   credit_avail     current credit count
//   credit_overflow  sticky error: a credit return was dropped
// ---------------------------------------------------------------------------
module ocx_tlx_dcp_xmt_credit_ctl #(
  parameter int addr_width = 7
) (
  input  logic                  tlx_clk,
  input  logic                  reset_n,
  input  logic                  credit_return_v,
  input  logic                  xmt_req_v,
  input  logic [2:0]            xmt_req_cnt,
  output logic                  xmt_req_ready,
  input  logic                  src_data_v,
  input  logic [511:0]          src_data_bus,
  output logic                  src_data_rd,
  input  logic                  link_stall,
  output logic                  fp_xmt_data_v,
  output logic [511:0]          fp_xmt_data_bus,
  output logic [addr_width:0]   credit_avail,
  output logic                  credit_overflow
);

  localparam logic [addr_width:0] CRED_MAX = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] CRED_ONE = {{addr_width{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CRED = 2'd1,
    SEND      = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            beats_left_q, beats_left_d;
  logic [addr_width:0]   credit_q, credit_d;
  logic [addr_width:0]   beats_left_ext;
  logic                  fp_v_q;
  logic [511:0]          fp_bus_q;
  logic                  pop;
  logic                  req_hs;

  // Burst length encoding: note 011 is 4 beats and 100 is 3 beats.
  function automatic logic [3:0] decode_len(input logic [2:0] cnt);
    case (cnt)
      3'b001:  decode_len = 4'd1;
      3'b010:  decode_len = 4'd2;
      3'b011:  decode_len = 4'd4;
      3'b100:  decode_len = 4'd3;
      3'b101:  decode_len = 4'd5;
      3'b110:  decode_len = 4'd6;
      3'b111:  decode_len = 4'd7;
      default: decode_len = 4'd8;
    endcase
  endfunction

  // Saturating credit update. A return at the maximum with no concurrent pop
  // is dropped. The decrement cannot underflow because the whole burst was
  // reserved before SEND was entered.
  function automatic logic [addr_width:0] credit_next(
    input logic [addr_width:0] cnt,
    input logic                inc,
    input logic                dec
  );
    if (inc && !dec) begin
      credit_next = (cnt == CRED_MAX) ? cnt : cnt + CRED_ONE;
    end else if (!inc && dec) begin
      credit_next = cnt - CRED_ONE;
    end else begin
      credit_next = cnt;
    end
  endfunction

  assign pop            = (state_q == SEND) & src_data_v & ~link_stall;
  assign xmt_req_ready  = reset_n & (state_q == IDLE);
  assign req_hs         = xmt_req_v & xmt_req_ready;
  assign beats_left_ext = (addr_width + 1)'(beats_left_q);
  assign credit_d       = credit_next(credit_q, credit_return_v, pop);

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          beats_left_d = decode_len(xmt_req_cnt);
          state_d      = WAIT_CRED;
        end
      end
      WAIT_CRED: begin
        // Decision uses the registered count, so a credit returned this
        // cycle only counts from the next cycle onward.
        if (credit_q >= beats_left_ext) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (pop) begin
          beats_left_d = beats_left_q - 4'd1;
          if (beats_left_q == 4'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- State / credit registers ----
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beats_left_q <= 4'd0;
      credit_q     <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      credit_q     <= credit_d;
    end
  end

  // ---- Framer output stage: one-cycle copy of the source pop ----
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      fp_v_q   <= 1'b0;
      fp_bus_q <= '0;
    end else begin
      fp_v_q   <= pop;
      fp_bus_q <= src_data_bus;
    end
  end

`ifdef OCX_TLX_DCP_XMT_OVERFLOW_CHK_EN
  logic ovf_q;
  logic cred_drop;

  assign cred_drop = credit_return_v & ~pop & (credit_q == CRED_MAX);

  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | cred_drop;
    end
  end

  assign credit_overflow = ovf_q;
`else
  assign credit_overflow = 1'b0;
`endif

  assign src_data_rd     = pop;
  assign fp_xmt_data_v   = fp_v_q;
  assign fp_xmt_data_bus = fp_bus_q;
  assign credit_avail    = credit_q;

endmodule

// File: tb/tb_ocx_tlx_dcp_xmt_credit_ctl.sv
module tb_ocx_tlx_dcp_xmt_credit_ctl;

  localparam int AW = 7;
`ifdef OCX_TLX_DCP_XMT_OVERFLOW_CHK_EN
  localparam bit OVF_EXP = 1'b1;
`else
  localparam bit OVF_EXP = 1'b0;
`endif

  logic          tlx_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          credit_return_v = 1'b0;
  logic          xmt_req_v = 1'b0;
  logic [2:0]    xmt_req_cnt = 3'b0;
  logic          xmt_req_ready;
  logic          src_data_v = 1'b0;
  logic [511:0]  src_data_bus = '0;
  logic          src_data_rd;
  logic          link_stall = 1'b0;
  logic          fp_xmt_data_v;
  logic [511:0]  fp_xmt_data_bus;
  logic [AW:0]   credit_avail;
  logic          credit_overflow;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 tlx_clk = ~tlx_clk;

  ocx_tlx_dcp_xmt_credit_ctl #(.addr_width(AW)) dut (
    .tlx_clk         (tlx_clk),
    .reset_n         (reset_n),
    .credit_return_v (credit_return_v),
    .xmt_req_v       (xmt_req_v),
    .xmt_req_cnt     (xmt_req_cnt),
    .xmt_req_ready   (xmt_req_ready),
    .src_data_v      (src_data_v),
    .src_data_bus    (src_data_bus),
    .src_data_rd     (src_data_rd),
    .link_stall      (link_stall),
    .fp_xmt_data_v   (fp_xmt_data_v),
    .fp_xmt_data_bus (fp_xmt_data_bus),
    .credit_avail    (credit_avail),
    .credit_overflow (credit_overflow)
  );

  typedef struct {
    bit        rst;
    bit        cr;
    bit        rv;
    bit [2:0]  cnt;
    bit        sv;
    bit        st;
    bit [31:0] d;
    bit        erdy;
    bit        erd;
    bit        efv;
    int        ecred;
    bit        eovf;
    bit        edchk;
    bit [31:0] ed;
  } vec_t;

  function automatic vec_t V(input bit rst, input bit cr, input bit rv,
                             input bit [2:0] cnt, input bit sv, input bit st,
                             input bit [31:0] d, input bit erdy, input bit erd,
                             input bit efv, input int ecred, input bit eovf,
                             input bit edchk, input bit [31:0] ed);
    vec_t v;
    v.rst = rst; v.cr = cr; v.rv = rv; v.cnt = cnt; v.sv = sv; v.st = st;
    v.d = d; v.erdy = erdy; v.erd = erd; v.efv = efv; v.ecred = ecred;
    v.eovf = eovf; v.edchk = edchk; v.ed = ed;
    return v;
  endfunction

  function automatic logic [511:0] rep(input bit [31:0] s);
    return {16{s}};
  endfunction

  // Inputs change on the falling edge; outputs are compared 2 time units
  // later, before the next rising edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    bit ok;
    @(negedge tlx_clk);
    reset_n         = v.rst;
    credit_return_v = v.cr;
    xmt_req_v       = v.rv;
    xmt_req_cnt     = v.cnt;
    src_data_v      = v.sv;
    link_stall      = v.st;
    src_data_bus    = rep(v.d);
    #2;
    ok = (xmt_req_ready == v.erdy) && (src_data_rd == v.erd) &&
         (fp_xmt_data_v == v.efv) && (int'(credit_avail) == v.ecred) &&
         (credit_overflow == v.eovf) &&
         (!v.edchk || (fp_xmt_data_bus == rep(v.ed)));
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s[%0d]: got rdy=%0d rd=%0d fv=%0d cred=%0d ovf=%0d bus=%h, want rdy=%0d rd=%0d fv=%0d cred=%0d ovf=%0d bus=%h(chk=%0d)",
               tag, idx, xmt_req_ready, src_data_rd, fp_xmt_data_v, credit_avail,
               credit_overflow, fp_xmt_data_bus[31:0], v.erdy, v.erd, v.efv,
               v.ecred, v.eovf, v.ed, v.edchk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];

    // Reset state, then 8 credits and an 8-beat burst (cnt=000).
    tbl.push_back(V(0,0,0,3'b000,0,0,0,       0,0,0,0,0,1,0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(V(1,1,0,3'b000,0,0,0,     1,0,0,i,0,0,0));
    tbl.push_back(V(1,0,1,3'b000,0,0,0,       1,0,0,8,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h10,    0,0,0,8,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h11,    0,1,0,8,0,0,0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(V(1,0,0,3'b000,1,0,'h12+k, 0,1,1,7-k,0,1,'h11+k));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h19,    1,0,1,0,0,1,'h18));
    tbl.push_back(V(1,0,0,3'b000,0,0,0,       1,0,0,0,0,0,0));

    // 3 credits, 4-beat request waits; 4th credit in cycle M gives pop at M+2.
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(1,1,0,3'b000,0,0,0,     1,0,0,i,0,0,0));
    tbl.push_back(V(1,0,1,3'b011,1,0,'h24,    1,0,0,3,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h25,    0,0,0,3,0,0,0));
    tbl.push_back(V(1,1,0,3'b000,1,0,'h26,    0,0,0,3,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h27,    0,0,0,4,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h28,    0,1,0,4,0,0,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(V(1,0,0,3'b000,1,0,'h29+k, 0,1,1,3-k,0,1,'h28+k));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h32,    1,0,1,0,0,1,'h2b));

    // Credits returned on every beat of a 4-beat burst: count holds at 4.
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(1,1,0,3'b000,0,0,0,     1,0,0,i,0,0,0));
    tbl.push_back(V(1,0,1,3'b011,0,0,0,       1,0,0,4,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h38,    0,0,0,4,0,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(V(1,1,0,3'b000,1,0,'h39+k, 0,1,(k > 0),4,0,(k > 0),'h38+k));
    tbl.push_back(V(1,0,0,3'b000,0,0,0,       1,0,1,4,0,1,'h3c));

    // 5-beat burst with a 2-cycle link stall and one source gap.
    tbl.push_back(V(1,1,0,3'b000,0,0,0,       1,0,0,4,0,0,0));
    tbl.push_back(V(1,0,1,3'b101,0,0,0,       1,0,0,5,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h46,    0,0,0,5,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h47,    0,1,0,5,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,1,'h48,    0,0,1,4,0,1,'h47));
    tbl.push_back(V(1,0,0,3'b000,1,1,'h49,    0,0,0,4,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h50,    0,1,0,4,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h51,    0,1,1,3,0,1,'h50));
    tbl.push_back(V(1,0,0,3'b000,0,0,'h52,    0,0,1,2,0,1,'h51));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h53,    0,1,0,2,0,0,0));
    tbl.push_back(V(1,0,0,3'b000,1,0,'h54,    0,1,1,1,0,1,'h53));
    tbl.push_back(V(1,0,0,3'b000,0,0,0,       1,0,1,0,0,1,'h54));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], "table", i);

    // Saturation: 128 returns ramp the pool, the 129th is dropped.
    apply(V(0,0,0,3'b000,0,0,0, 0,0,0,0,0,1,0), "ramp_rst", 0);
    for (int i = 0; i < 128; i++)
      apply(V(1,1,0,3'b000,0,0,0, 1,0,0,i,0,0,0), "ramp", i);
    apply(V(1,1,0,3'b000,0,0,0, 1,0,0,128,0,0,0),       "sat129", 0);
    apply(V(1,0,0,3'b000,0,0,0, 1,0,0,128,OVF_EXP,0,0), "sat_ovf", 0);
    apply(V(1,1,0,3'b000,0,0,0, 1,0,0,128,OVF_EXP,0,0), "sat_ovf", 1);
    apply(V(1,0,0,3'b000,0,0,0, 1,0,0,128,OVF_EXP,0,0), "sat_sticky", 0);

    // Reset asserted during beat 2 of a 6-beat burst.
    apply(V(0,0,0,3'b000,0,0,0, 0,0,0,0,0,1,0), "mid_rst", 0);
    for (int i = 0; i < 6; i++)
      apply(V(1,1,0,3'b000,0,0,0, 1,0,0,i,0,0,0), "mid_cred", i);
    apply(V(1,0,1,3'b110,0,0,0,    1,0,0,6,0,0,0), "mid_req", 0);
    apply(V(1,0,0,3'b000,1,0,'h90, 0,0,0,6,0,0,0), "mid_wait", 0);
    apply(V(1,0,0,3'b000,1,0,'h91, 0,1,0,6,0,0,0), "mid_beat1", 0);
    apply(V(0,0,0,3'b000,1,0,'h92, 0,0,0,0,0,1,0), "mid_beat2_rst", 0);
    apply(V(1,0,0,3'b000,1,0,'h93, 1,0,0,0,0,1,0), "mid_release", 0);
    apply(V(1,0,0,3'b000,0,0,0,    1,0,0,0,0,0,0), "mid_idle", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
